// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - multi-cycle PC/fetch sequencer with im req/ack handshake
//
// Purpose: owns the program counter, fetches one instruction at a time from
// instruction memory, holds it in the instruction register while the datapath
// executes it, and computes the next PC from the controller's decisions.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   im_req/im_addr   read request and fetch address (im_addr == pc)
//   im_ack/im_rdata  memory response; word valid when im_ack=1
//   instr            instruction register (opcode/funct to the controller)
//   instr_valid      instr is the live instruction being executed
//   pc, link_pc      current instruction address and its pc+4
//   ALUOp/Jump/Link  controller decisions for the current instruction
//   zero, rs_data    ALU zero flag and register jump target
//   exec_done        datapath retires the current instruction
//   addr_err         sticky misaligned register-jump flag
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] link_pc,
  input  logic [3:0]  ALUOp,
  input  logic        Jump,
  input  logic        Link,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        exec_done,
  output logic        addr_err
);

  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JR   = 4'hC;
  localparam logic [3:0] OP_JALR = 4'hD;
  localparam logic [3:0] OP_J    = 4'hE;
  localparam logic [3:0] OP_JAL  = 4'hF;

  typedef enum logic [1:0] {IDLE, REQ, EXEC} state_t;

  state_t      state, state_d;
  logic [31:0] pc_d, instr_d, link_pc_d;
  logic        im_req_d, instr_valid_d, addr_err_d;

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        reg_jump;

  // Link only tells the write-back side to use link_pc; nothing here depends on it.
  logic unused_link;
  assign unused_link = Link;

  assign im_addr   = pc;
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign reg_jump  = Jump && (ALUOp == OP_JR || ALUOp == OP_JALR);

  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      case (ALUOp)
        OP_BEQ:          next_pc = zero ? br_target : pc4;
        OP_BNE:          next_pc = zero ? pc4 : br_target;
        OP_J, OP_JAL:    next_pc = {pc4[31:28], instr[25:0], 2'b00};
        OP_JR, OP_JALR:  next_pc = {rs_data[31:2], 2'b00};
        default:         next_pc = pc4;
      endcase
    end
  end

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instr_d       = instr;
    link_pc_d     = link_pc;
    im_req_d      = im_req;
    instr_valid_d = instr_valid;
    addr_err_d    = addr_err;
    case (state)
      IDLE: begin
        state_d  = REQ;
        im_req_d = 1'b1;
      end
      REQ: begin
        if (im_ack) begin
          state_d       = EXEC;
          instr_d       = im_rdata;
          link_pc_d     = pc4;
          im_req_d      = 1'b0;
          instr_valid_d = 1'b1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_d       = REQ;
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          im_req_d      = 1'b1;
          // Target is still aligned by dropping the low bits; the error only records it.
          if (reg_jump && (rs_data[1:0] != 2'b00)) addr_err_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        im_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      link_pc     <= 32'd0;
      im_req      <= 1'b0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      link_pc     <= link_pc_d;
      im_req      <= im_req_d;
      instr_valid <= instr_valid_d;
      addr_err    <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic [3:0]  ALUOp;
  logic        Jump;
  logic        Link;
  logic        zero;
  logic [31:0] rs_data;
  logic        exec_done;
  logic        addr_err;

  int vectors;
  int miscompares;

  logic [31:0] got_addr;
  bit          got_stable;

  localparam logic [31:0] ADD_W  = 32'h012A_4020;
  localparam logic [31:0] BEQ_W  = 32'h1000_FFFC;
  localparam logic [31:0] BNE_W  = 32'h1400_FFFC;
  localparam logic [31:0] J_W    = 32'h0800_0100;
  localparam logic [31:0] JAL_W  = 32'h0C00_0100;
  localparam logic [31:0] JR_W   = 32'h03E0_0008;
  localparam logic [31:0] JALR_W = 32'h0120_F809;

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .link_pc(link_pc), .ALUOp(ALUOp), .Jump(Jump), .Link(Link),
    .zero(zero), .rs_data(rs_data), .exec_done(exec_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory side: waits for a request, holds ack low for 'waits' cycles, then acks.
  task automatic serve_fetch(input logic [31:0] word, input int waits);
    int n;
    n = 0;
    while (im_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (im_req !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_timeout im_req=%b required 1", im_req);
    end
    got_addr   = im_addr;
    got_stable = 1'b1;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (im_addr !== got_addr || im_req !== 1'b1 || instr_valid !== 1'b0) got_stable = 1'b0;
    end
    im_rdata = word;
    im_ack   = 1'b1;
    @(negedge clk);
    im_ack   = 1'b0;
    im_rdata = 32'd0;
  endtask

  // Datapath side: presents controller decisions and retires after 'waits' cycles.
  task automatic serve_exec(input logic j, input logic [3:0] op, input logic z,
                            input logic [31:0] rs, input logic lnk, input int waits);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL exec_timeout instr_valid=%b required 1", instr_valid);
    end
    Jump = j; ALUOp = op; zero = z; rs_data = rs; Link = lnk;
    repeat (waits) @(negedge clk);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    Jump = 1'b0; ALUOp = 4'h0; zero = 1'b0; rs_data = 32'd0; Link = 1'b0;
  endtask

  task automatic goto_addr(input logic [31:0] target);
    serve_fetch(JR_W, 0);
    serve_exec(1'b1, 4'hC, 1'b0, target, 1'b0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL rst_im_req got %b exp 0", im_req); end
    vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", pc); end
    vectors++; if (im_addr !== 32'd0) begin miscompares++; $display("FAIL rst_im_addr got %h exp 0", im_addr); end
    vectors++; if (instr !== 32'd0) begin miscompares++; $display("FAIL rst_instr got %h exp 0", instr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
    vectors++; if (link_pc !== 32'd0) begin miscompares++; $display("FAIL rst_link_pc got %h exp 0", link_pc); end
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL rst_addr_err got %b exp 0", addr_err); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (im_req !== 1'b1) begin miscompares++; $display("FAIL idle_to_req im_req got %b exp 1", im_req); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      serve_fetch(ADD_W, 1);
      vectors++; if (got_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_addr[%0d] got %h exp %h", i, got_addr, 32'(i * 4)); end
      vectors++; if (instr !== ADD_W) begin miscompares++; $display("FAIL seq_instr[%0d] got %h exp %h", i, instr, ADD_W); end
      vectors++; if (link_pc !== 32'(i * 4 + 4)) begin miscompares++; $display("FAIL seq_link_pc[%0d] got %h exp %h", i, link_pc, 32'(i * 4 + 4)); end
      vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL seq_req_drop[%0d] got %b exp 0", i, im_req); end
      serve_exec(1'b0, 4'h0, 1'b0, 32'd0, 1'b0, 1);
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL seq_valid_drop[%0d] got %b exp 0", i, instr_valid); end
    end
  endtask

  task automatic test_branch;
    goto_addr(32'h40);
    serve_fetch(BEQ_W, 0);
    vectors++; if (got_addr !== 32'h40) begin miscompares++; $display("FAIL beq_fetch_addr got %h exp 00000040", got_addr); end
    serve_exec(1'b1, 4'hA, 1'b1, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h34) begin miscompares++; $display("FAIL beq_taken got %h exp 00000034", im_addr); end
    goto_addr(32'h40);
    serve_fetch(BEQ_W, 0);
    serve_exec(1'b1, 4'hA, 1'b0, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h44) begin miscompares++; $display("FAIL beq_not_taken got %h exp 00000044", im_addr); end
    goto_addr(32'h40);
    serve_fetch(BNE_W, 0);
    serve_exec(1'b1, 4'hB, 1'b0, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h34) begin miscompares++; $display("FAIL bne_taken got %h exp 00000034", im_addr); end
    goto_addr(32'h40);
    serve_fetch(BNE_W, 0);
    serve_exec(1'b1, 4'hB, 1'b1, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h44) begin miscompares++; $display("FAIL bne_not_taken got %h exp 00000044", im_addr); end
    goto_addr(32'h40);
    serve_fetch(BEQ_W, 0);
    serve_exec(1'b1, 4'h2, 1'b1, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h44) begin miscompares++; $display("FAIL other_aluop got %h exp 00000044", im_addr); end
  endtask

  task automatic test_jumps;
    goto_addr(32'h1000_0010);
    serve_fetch(J_W, 0);
    serve_exec(1'b1, 4'hE, 1'b0, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h1000_0400) begin miscompares++; $display("FAIL j_target got %h exp 10000400", im_addr); end
    goto_addr(32'h1000_0010);
    serve_fetch(JAL_W, 0);
    vectors++; if (link_pc !== 32'h1000_0014) begin miscompares++; $display("FAIL jal_link_pc got %h exp 10000014", link_pc); end
    serve_exec(1'b1, 4'hF, 1'b0, 32'd0, 1'b1, 0);
    vectors++; if (im_addr !== 32'h1000_0400) begin miscompares++; $display("FAIL jal_target got %h exp 10000400", im_addr); end
    goto_addr(32'h200);
    serve_fetch(J_W, 0);
    serve_exec(1'b0, 4'hE, 1'b0, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'h204) begin miscompares++; $display("FAIL jump0_ignores_aluop got %h exp 00000204", im_addr); end
  endtask

  task automatic test_reg_jump;
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL addr_err_pre got %b exp 0", addr_err); end
    serve_fetch(JR_W, 0);
    serve_exec(1'b1, 4'hC, 1'b0, 32'h0000_2002, 1'b0, 0);
    vectors++; if (im_addr !== 32'h2000) begin miscompares++; $display("FAIL jr_target got %h exp 00002000", im_addr); end
    vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("FAIL jr_addr_err got %b exp 1", addr_err); end
    serve_fetch(JALR_W, 0);
    serve_exec(1'b1, 4'hD, 1'b0, 32'h0000_3000, 1'b1, 0);
    vectors++; if (im_addr !== 32'h3000) begin miscompares++; $display("FAIL jalr_target got %h exp 00003000", im_addr); end
    vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("FAIL addr_err_sticky got %b exp 1", addr_err); end
  endtask

  task automatic test_handshake;
    logic [31:0] pc_now;
    serve_fetch(32'hAAAA_5555, 0);
    vectors++; if (instr !== 32'hAAAA_5555) begin miscompares++; $display("FAIL zero_wait_instr got %h exp aaaa5555", instr); end
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL zero_wait_valid got %b exp 1", instr_valid); end
    pc_now   = pc;
    im_ack   = 1'b1;
    im_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    im_ack   = 1'b0;
    im_rdata = 32'd0;
    vectors++; if (instr !== 32'hAAAA_5555) begin miscompares++; $display("FAIL spurious_ack_instr got %h exp aaaa5555", instr); end
    vectors++; if (im_req !== 1'b0 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL spurious_ack_state got req=%b valid=%b exp req=0 valid=1", im_req, instr_valid); end
    serve_exec(1'b0, 4'h0, 1'b0, 32'd0, 1'b0, 0);
    exec_done = 1'b1;
    repeat (2) @(negedge clk);
    exec_done = 1'b0;
    vectors++; if (pc !== pc_now + 32'd4) begin miscompares++; $display("FAIL spurious_done_pc got %h exp %h", pc, pc_now + 32'd4); end
    vectors++; if (im_req !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL spurious_done_state got req=%b valid=%b exp req=1 valid=0", im_req, instr_valid); end
    serve_fetch(ADD_W, 5);
    vectors++; if (got_stable !== 1'b1) begin miscompares++; $display("FAIL delayed_ack_stable got %b exp 1", got_stable); end
    vectors++; if (got_addr !== pc_now + 32'd4) begin miscompares++; $display("FAIL delayed_ack_addr got %h exp %h", got_addr, pc_now + 32'd4); end
    serve_exec(1'b0, 4'h0, 1'b0, 32'd0, 1'b0, 2);
  endtask

  task automatic test_wrap;
    goto_addr(32'hFFFF_FFFC);
    serve_fetch(ADD_W, 0);
    vectors++; if (link_pc !== 32'd0) begin miscompares++; $display("FAIL wrap_link_pc got %h exp 00000000", link_pc); end
    serve_exec(1'b0, 4'h0, 1'b0, 32'd0, 1'b0, 0);
    vectors++; if (im_addr !== 32'd0) begin miscompares++; $display("FAIL wrap_pc got %h exp 00000000", im_addr); end
  endtask

  task automatic test_async_reset;
    goto_addr(32'h80);
    im_rdata = 32'hDEAD_BEEF;
    im_ack   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL async_pc got %h exp 00000000", pc); end
    vectors++; if (instr !== 32'd0) begin miscompares++; $display("FAIL async_instr got %h exp 00000000", instr); end
    vectors++; if (im_req !== 1'b0 || addr_err !== 1'b0) begin miscompares++; $display("FAIL async_flags got req=%b err=%b exp 0 0", im_req, addr_err); end
    @(negedge clk);
    vectors++; if (instr !== 32'd0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL async_ack_ignored got instr=%h valid=%b exp 0 0", instr, instr_valid); end
    im_ack   = 1'b0;
    im_rdata = 32'd0;
    rst_n    = 1'b1;
    serve_fetch(ADD_W, 0);
    vectors++; if (got_addr !== 32'd0) begin miscompares++; $display("FAIL restart_addr got %h exp 00000000", got_addr); end
    vectors++; if (instr !== ADD_W) begin miscompares++; $display("FAIL restart_instr got %h exp %h", instr, ADD_W); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    im_ack    = 1'b0;
    im_rdata  = 32'd0;
    ALUOp     = 4'h0;
    Jump      = 1'b0;
    Link      = 1'b0;
    zero      = 1'b0;
    rs_data   = 32'd0;
    exec_done = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jumps();
    test_reg_jump();
    test_handshake();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch/sequencing stage for the MIPS-subset core.
- Owns the program counter and performs a req/ack handshake with instruction memory.
- Holds the fetched word in an instruction register that drives opcode/funct into the decode controller.
- Consumes the controller's ALUOp/Jump/Link decisions plus the ALU zero flag to compute the next PC when the datapath retires the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- im_req  out  1  instruction-memory read request.
- im_addr  out  32  fetch address (equals pc).
- im_ack  in  1  memory has im_rdata valid this cycle.
- im_rdata  in  32  fetched instruction word.
- instr  out  32  instruction register; [31:26] opcode and [5:0] funct go to the controller.
- instr_valid  out  1  instr holds a live instruction being executed.
- pc  out  32  current instruction address.
- link_pc  out  32  pc+4 of the current instruction, for JAL/JALR write-back.
- ALUOp  in  4  controller opcode (BEQ=4'hA, BNE=4'hB, JR=4'hC, JALR=4'hD, J=4'hE, JAL=4'hF).
- Jump  in  1  controller: control-transfer instruction.
- Link  in  1  controller: link instruction (informational; link_pc is always driven).
- zero  in  1  ALU result == 0 for the current instruction.
- rs_data  in  32  register-file rs value, the JR/JALR target.
- exec_done  in  1  datapath has completed the current instruction this cycle.
- addr_err  out  1  sticky flag: misaligned register jump target.

Behaviour:
- Reset (async, rst_n=0), all immediate:
  - state=IDLE, pc=RESET_PC, im_req=0, instr=0, instr_valid=0, link_pc=0, addr_err=0.
  - Reset asserted mid-fetch or mid-execute aborts; a pending im_ack is ignored.
- States IDLE, REQ, EXEC, all outputs registered:
  - IDLE: first rising edge with rst_n=1 -> REQ, im_req<=1.
  - REQ: im_req=1, im_addr=pc held stable until ack. On an edge with im_ack=1: instr<=im_rdata, link_pc<=pc+4, im_req<=0, instr_valid<=1, ->EXEC.
    - im_ack may arrive in the same cycle im_req first rises (zero-wait memory), so minimum fetch is 1 cycle in REQ.
  - EXEC: instr held constant. On an edge with exec_done=1: pc<=next_pc, instr_valid<=0, im_req<=1, ->REQ.
    - Instruction period is therefore at least 2 cycles.
- Input sampling:
  - im_ack outside REQ is ignored.
  - exec_done outside EXEC is ignored.
- next_pc (combinational, 32-bit, wraps mod 2^32), with pc4=pc+4:
  - Jump=0: pc4, regardless of ALUOp.
  - Jump=1 & ALUOp=BEQ: zero ? pc4+(sext(instr[15:0])<<2) : pc4.
  - Jump=1 & ALUOp=BNE: !zero ? branch target : pc4.
  - Jump=1 & ALUOp in {J,JAL}: {pc4[31:28], instr[25:0], 2'b00}.
  - Jump=1 & ALUOp in {JR,JALR}: {rs_data[31:2], 2'b00}. If rs_data[1:0]!=0, addr_err<=1 (sticky until reset).
  - Jump=1 & any other ALUOp: pc4.
- pc=32'hFFFF_FFFC with sequential flow wraps to 0.
- No speculative prefetch: exactly one outstanding request at a time.

Test Plan:
- Reset/sequential: RESET_PC=0, memory acks 1 cycle after req with ADD words, exec_done 1 cycle after instr_valid -> im_addr sequence 0,4,8,12; link_pc=4 while executing pc=0; all outputs 0 during reset.
- Branch taken: BEQ at pc=0x40, imm=16'hFFFC, Jump=1, ALUOp=4'hA, zero=1 -> next im_addr=0x34. Same with zero=0 -> 0x44. BNE with zero=0 -> 0x34.
- Jumps: J at pc=0x1000_0010, instr[25:0]=26'h0000100 -> im_addr=0x1000_0400. JAL same target with link_pc=0x1000_0014.
- Register jump: JR with rs_data=0x0000_2002 -> im_addr=0x2000 and addr_err=1 sticky. JALR with rs_data=0x3000 -> im_addr=0x3000, addr_err unchanged.
- Handshake corners:
  - Zero-wait ack (im_ack high on the first REQ cycle) -> instr latched next edge.
  - 5-cycle ack delay -> im_addr stable throughout.
  - Spurious im_ack during EXEC and exec_done during REQ -> no state change.
- Async reset mid-operation: drop rst_n during REQ with im_ack=1 that cycle -> instr stays 0, pc=RESET_PC immediately. On release, fetch restarts from RESET_PC.
